// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: FETCH/EXEC/HALT control for the microprogram.
// Ports: clock, reset, cs_addr/cs_data store, mbr/alu_n/alu_z, MIR, ALU, halted, step (MIC1_SEQ_STEP_EN).
module mic1_sequencer (
  input  logic        clock,
  input  logic        reset,
  output logic [8:0]  cs_addr,
  input  logic [35:0] cs_data,
  input  logic [7:0]  mbr,
  input  logic        alu_n,
  input  logic        alu_z,
`ifdef MIC1_SEQ_STEP_EN
  input  logic        step,
`endif
  output logic [15:0] MIR,
  output logic [7:0]  ALU,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [8:0] HALT_ADDR = 9'h1FF;

  state_e      state_q;
  logic [8:0]  mpc_q;
  logic [35:0] mir_q;
  logic        halted_q;

  logic [8:0]  nxt_addr;
  logic [7:0]  nxt_lo;
  logic        nxt_hi;
  logic        adv_fetch;

  // Microinstruction field views
  logic [8:0]  f_next;
  logic        f_jmpc;
  logic        f_jamn;
  logic        f_jamz;

  assign f_next = mir_q[35:27];
  assign f_jmpc = mir_q[26];
  assign f_jamn = mir_q[25];
  assign f_jamz = mir_q[24];

  // Jams are ORed in, never added: no carry into bit 8.
  always_comb begin
    nxt_hi   = f_next[8]
             | (f_jamn & alu_n)
             | (f_jamz & alu_z);
    nxt_lo   = f_next[7:0]
             | (f_jmpc ? mbr : 8'h00);
    nxt_addr = {nxt_hi, nxt_lo};
  end

`ifdef MIC1_SEQ_STEP_EN
  assign adv_fetch = step;
`else
  assign adv_fetch = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      mpc_q    <= 9'h000;
      mir_q    <= 36'h0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (adv_fetch) begin
            mir_q   <= cs_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          mpc_q <= nxt_addr;
          if (nxt_addr == HALT_ADDR) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= S_FETCH;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign cs_addr = mpc_q;
  assign ALU     = mir_q[23:16];
  assign halted  = halted_q;

  // C-bus enables and memory strobes fire only in EXEC;
  // B select stays visible so the bus is stable beforehand.
  assign MIR = (state_q == S_EXEC) ? mir_q[15:0]
                                   : {12'h000, mir_q[3:0]};

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed bench for mic1_sequencer.
// Control store modelled as a small array addressed by cs_addr.
module tb_mic1_sequencer;

  logic        clock;
  logic        reset;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic [7:0]  mbr;
  logic        alu_n;
  logic        alu_z;
  logic        step;
  logic [15:0] MIR;
  logic [7:0]  ALU;
  logic        halted;

  logic [35:0] rom [512];
  int          checks;
  int          errors;
  logic        seen033;

  mic1_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .cs_addr (cs_addr),
    .cs_data (cs_data),
    .mbr     (mbr),
    .alu_n   (alu_n),
    .alu_z   (alu_z),
`ifdef MIC1_SEQ_STEP_EN
    .step    (step),
`endif
    .MIR     (MIR),
    .ALU     (ALU),
    .halted  (halted)
  );

  assign cs_data = rom[cs_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (cs_addr == 9'h033) seen033 = 1'b1;

  function automatic logic [35:0] mk(
    input logic [8:0]  nxt,
    input logic        jmpc,
    input logic        jamn,
    input logic        jamz,
    input logic [7:0]  alu,
    input logic [15:0] word
  );
    return {nxt, jmpc, jamn, jamz, alu, word};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    seen033 = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 36'h0;
    rom[9'h000] = mk(9'h005, 0, 0, 0, 8'h3C, 16'h8001);
    rom[9'h005] = mk(9'h012, 0, 0, 1, 8'h00, 16'h4002);
    rom[9'h112] = mk(9'h012, 0, 0, 1, 8'h00, 16'h0000);
    rom[9'h012] = mk(9'h000, 1, 0, 0, 8'h00, 16'h0000);
    rom[9'h059] = mk(9'h100, 1, 0, 0, 8'h00, 16'h0000);
    rom[9'h1A7] = mk(9'h0C0, 0, 1, 1, 8'h00, 16'h0000);
    rom[9'h1C0] = mk(9'h0F0, 1, 0, 0, 8'h00, 16'h0000);
    rom[9'h0FF] = mk(9'h1FF, 0, 0, 0, 8'h5A, 16'hFFF5);

    reset = 1'b1;
    alu_n = 1'b0;
    alu_z = 1'b0;
    mbr   = 8'h00;
    step  = 1'b1;

    tick();
    check("rst_addr", {7'h0, cs_addr}, 16'h0000);
    check("rst_mir", MIR, 16'h0000);
    check("rst_alu", {8'h0, ALU}, 16'h0000);
    check("rst_halt", {15'h0, halted}, 16'h0000);

    reset = 1'b0;
    tick();
    check("seq_exec_mir", MIR, 16'h8001);
    check("seq_exec_alu", {8'h0, ALU}, 16'h003C);
    check("seq_exec_addr", {7'h0, cs_addr}, 16'h0000);
    tick();
    check("seq_next", {7'h0, cs_addr}, 16'h0005);
    check("seq_fetch_mir", MIR, 16'h0001);

    alu_z = 1'b1;
    tick();
    check("jamz_exec_mir", MIR, 16'h4002);
    tick();
    check("jamz1", {7'h0, cs_addr}, 16'h0112);
    check("jamz1_fetch_mir", MIR, 16'h0002);

    alu_z = 1'b0;
    tick(); tick();
    check("jamz0", {7'h0, cs_addr}, 16'h0012);

    mbr = 8'h59;
    tick(); tick();
    check("jmpc59", {7'h0, cs_addr}, 16'h0059);

    mbr = 8'hA7;
    tick(); tick();
    check("jmpcA7", {7'h0, cs_addr}, 16'h01A7);

    alu_n = 1'b1;
    alu_z = 1'b1;
    tick(); tick();
    check("jam_or", {7'h0, cs_addr}, 16'h01C0);

    alu_n = 1'b0;
    alu_z = 1'b0;
    mbr   = 8'hFF;
    tick(); tick();
    check("no_carry", {7'h0, cs_addr}, 16'h00FF);

    tick();
    check("pre_halt_mir", MIR, 16'hFFF5);
    check("pre_halt", {15'h0, halted}, 16'h0000);
    tick();
    check("halted", {15'h0, halted}, 16'h0001);
    check("halt_mir", MIR, 16'h0005);
    check("halt_alu", {8'h0, ALU}, 16'h005A);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_hold", {7'h0, cs_addr}, 16'h01FF);
    end
    check("halt_stays", {15'h0, halted}, 16'h0001);

    reset = 1'b1;
    tick();
    check("unhalt_addr", {7'h0, cs_addr}, 16'h0000);
    check("unhalt_flag", {15'h0, halted}, 16'h0000);
    check("unhalt_mir", MIR, 16'h0000);

    rom[9'h000] = mk(9'h033, 0, 0, 0, 8'h11, 16'hFFFF);
    reset = 1'b0;
    tick();
    check("midx_exec_mir", MIR, 16'hFFFF);
    reset = 1'b1;
    tick();
    check("midx_addr", {7'h0, cs_addr}, 16'h0000);
    check("midx_mir", MIR, 16'h0000);
    check("midx_alu", {8'h0, ALU}, 16'h0000);
    rom[9'h000] = mk(9'h005, 0, 0, 0, 8'h3C, 16'h8001);
    reset = 1'b0;
    check("never033", {15'h0, seen033}, 16'h0000);

`ifdef MIC1_SEQ_STEP_EN
    tick(); tick();
    check("stp_addr5", {7'h0, cs_addr}, 16'h0005);
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stp_hold_addr", {7'h0, cs_addr}, 16'h0005);
      check("stp_hold_mir", MIR, 16'h0001);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    check("stp_exec_mir", MIR, 16'h4002);
    tick();
    check("stp_next", {7'h0, cs_addr}, 16'h0012);
    tick(); tick();
    check("stp_one_only", {7'h0, cs_addr}, 16'h0012);
    check("stp_fetch_mir", MIR, 16'h0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
